// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared encodings, fetch state enum and branch-offset helper
// Contents: PCSEL_* decoder pcMuxSel encodings, fetch_state_e, br_offset().
package mips_fetch_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JR  = 2'b10;
    localparam logic [1:0] PCSEL_J   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } fetch_state_e;

    // Sign-extended 16-bit immediate scaled to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// rtl/mips_fetch_if.sv - instruction-memory and decode-side handshake bundle of the fetch stage
// imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata : single-outstanding fetch bus
// inst/inst_pc/inst_valid/inst_ready                 : instruction hand-off to decode
// ctl_pcsel/ctl_br_taken/ctl_jr_target/ctl_sys       : decoder feedback, valid on accept
// modport master: fetch stage side; modport slave: memory/decode side.
interface mips_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  ctl_pcsel;
    logic        ctl_br_taken;
    logic [31:0] ctl_jr_target;
    logic        ctl_sys;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst, inst_pc, inst_valid,
        input  inst_ready, ctl_pcsel, ctl_br_taken, ctl_jr_target, ctl_sys
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst, inst_pc, inst_valid,
        output inst_ready, ctl_pcsel, ctl_br_taken, ctl_jr_target, ctl_sys
    );
endinterface

// File: rtl/mips_fetch_next_pc.sv
// rtl/mips_fetch_next_pc.sv - combinational next-PC / redirect target computation (module mips_next_pc)
// Inputs : pc (PC of the accepted inst), inst[25:0] (immediate / instr_index field),
//          ctl_pcsel, ctl_br_taken, ctl_jr_target
// Outputs: seq_pc (pc+4), redirect, target, misaligned (redirect target not word aligned)
module mips_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] inst,
    input  logic [1:0]  ctl_pcsel,
    input  logic        ctl_br_taken,
    input  logic [31:0] ctl_jr_target,
    output logic [31:0] seq_pc,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        // Branch and jump targets are relative to the delay slot address.
        seq_pc   = pc + 32'd4;
        redirect = 1'b0;
        target   = seq_pc;
        case (ctl_pcsel)
            PCSEL_BR: begin
                redirect = ctl_br_taken;
                target   = seq_pc + br_offset(inst[15:0]);
            end
            PCSEL_JR: begin
                redirect = 1'b1;
                target   = ctl_jr_target;
            end
            PCSEL_J: begin
                redirect = 1'b1;
                target   = {seq_pc[31:28], inst, 2'b00};
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
        misaligned = redirect && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - MIPS instruction fetch stage with single branch delay slot
// clk, rst     : clock, asynchronous active-high reset
// bus (master) : imem req/gnt/rvalid fetch bus and inst valid/ready hand-off with ctl_* feedback
// halted       : fetch stopped by syscall or misaligned redirect
// addr_err     : sticky misaligned-redirect flag
// perf_fetched, perf_stall : accept and stall counters, present only with MIPS_FETCH_PERF_EN
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          rst,
    mips_fetch_if.master  bus,
    output logic          halted,
    output logic          addr_err
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         pend_mis_q, pend_mis_d;
    logic         addr_err_q, addr_err_d;

    logic         accept;
    logic [31:0]  seq_pc;
    logic         redirect;
    logic [31:0]  target;
    logic         misaligned;

    mips_next_pc u_next_pc (
        .pc            (inst_pc_q),
        .inst          (inst_q[25:0]),
        .ctl_pcsel     (bus.ctl_pcsel),
        .ctl_br_taken  (bus.ctl_br_taken),
        .ctl_jr_target (bus.ctl_jr_target),
        .seq_pc        (seq_pc),
        .redirect      (redirect),
        .target        (target),
        .misaligned    (misaligned)
    );

    assign accept         = (state_q == S_VALID) && bus.inst_ready;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = (state_q == S_VALID);
    assign halted         = (state_q == S_HALT);
    assign addr_err       = addr_err_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_mis_d    = pend_mis_q;
        addr_err_d    = addr_err_q;
        bus.imem_req  = 1'b0;

        case (state_q)
            // Any rvalid left over from a request abandoned by reset lands here and is dropped.
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                bus.imem_req = 1'b1;
                if (bus.imem_gnt) begin
                    if (bus.imem_rvalid) begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = fetch_pc_q;
                        state_d   = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = fetch_pc_q;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                if (accept) begin
                    fetch_pc_d = seq_pc;
                    state_d    = S_REQ;
                    if (pend_valid_q) begin
                        // This is the delay slot: consume the latched redirect. A redirect
                        // decoded here (branch in delay slot) is ignored.
                        pend_valid_d = 1'b0;
                        if (pend_mis_q) begin
                            addr_err_d = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            fetch_pc_d = pend_target_q;
                        end
                    end else if (redirect) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = target;
                        pend_mis_d    = misaligned;
                    end
                    if (bus.ctl_sys) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            pend_mis_q    <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_mis_q    <= pend_mis_d;
            addr_err_q    <= addr_err_d;
        end
    end

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (accept) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (bus.inst_valid && !bus.inst_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// tb/tb_mips_fetch.sv - scoreboard testbench for mips_fetch
module tb_mips_fetch;
    import mips_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    logic addr_err;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    mips_fetch_if fbus ();

    mips_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (fbus),
        .halted       (halted),
        .addr_err     (addr_err)
`ifdef MIPS_FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          halt_after;
        bit          err_after;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_g[$];
    logic [31:0] grant_log[$];

    logic [31:0] p_inst[logic [31:0]];
    logic [1:0]  p_sel[logic [31:0]];
    bit          p_tk[logic [31:0]];
    logic [31:0] p_jr[logic [31:0]];
    bit          p_sys[logic [31:0]];
    int          p_stall[logic [31:0]];

    int errors = 0;
    int checks = 0;

    int gnt_dly = 0, rv_dly = 0, def_stall = 0;
    int gnt_cnt = 0, rv_cnt = 0, stall_cnt = 0;
    bit ready_en = 1'b0, rv_pend = 1'b0, stale = 1'b0;
    bit chk_halt = 1'b0, exp_halt = 1'b0, exp_err = 1'b0, req_seen = 1'b0;
    logic [31:0] rv_addr = 32'd0, req_addr = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (p_inst.exists(a)) return p_inst[a];
        return {16'h2400, a[15:0]};
    endfunction

    function automatic int stall_for(input logic [31:0] a);
        if (p_stall.exists(a)) return p_stall[a];
        return def_stall;
    endfunction

    // Memory model, decode model (ready + ctl) and scoreboard monitor, all on the falling edge.
    initial begin
        fbus.imem_gnt      = 1'b0;
        fbus.imem_rvalid   = 1'b0;
        fbus.imem_rdata    = 32'd0;
        fbus.inst_ready    = 1'b0;
        fbus.ctl_pcsel     = PCSEL_SEQ;
        fbus.ctl_br_taken  = 1'b0;
        fbus.ctl_jr_target = 32'd0;
        fbus.ctl_sys       = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_halt) begin
                check32("halted_after_accept", {31'd0, halted}, {31'd0, exp_halt});
                check32("addr_err_after_accept", {31'd0, addr_err}, {31'd0, exp_err});
                chk_halt = 1'b0;
            end
            if (!ready_en) begin
                fbus.inst_ready = 1'b0;
            end else if (fbus.inst_valid && stall_cnt < stall_for(fbus.inst_pc)) begin
                fbus.inst_ready = 1'b0;
                stall_cnt++;
            end else begin
                fbus.inst_ready = 1'b1;
                if (fbus.inst_valid) stall_cnt = 0;
            end
            if (fbus.inst_valid) begin
                if (q.size() > 0) begin
                    check32("inst_pc", fbus.inst_pc, q[0].pc);
                    check32("inst", fbus.inst, mem_word(q[0].pc));
                    if (fbus.inst_ready) begin
                        chk_halt = 1'b1;
                        exp_halt = q[0].halt_after;
                        exp_err  = q[0].err_after;
                        void'(q.pop_front());
                    end
                end else if (fbus.inst_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: pc %h accepted, scoreboard empty", fbus.inst_pc);
                end
            end
            fbus.imem_gnt    = 1'b0;
            fbus.imem_rvalid = 1'b0;
            if (fbus.imem_req) begin
                if (req_seen) check32("imem_addr_stable", fbus.imem_addr, req_addr);
                req_seen = 1'b1;
                req_addr = fbus.imem_addr;
            end
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    fbus.imem_rvalid = 1'b1;
                    fbus.imem_rdata  = stale ? 32'hBAD0_0001 : mem_word(rv_addr);
                    rv_pend = 1'b0;
                    stale   = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (fbus.imem_req) begin
                if (gnt_cnt >= gnt_dly) begin
                    fbus.imem_gnt = 1'b1;
                    gnt_cnt  = 0;
                    req_seen = 1'b0;
                    grant_log.push_back(fbus.imem_addr);
                    if (rv_dly == 0) begin
                        fbus.imem_rvalid = 1'b1;
                        fbus.imem_rdata  = mem_word(fbus.imem_addr);
                    end else begin
                        rv_pend = 1'b1;
                        rv_cnt  = rv_dly - 1;
                        rv_addr = fbus.imem_addr;
                    end
                end else begin
                    gnt_cnt++;
                end
            end
            fbus.ctl_pcsel     = p_sel.exists(fbus.inst_pc) ? p_sel[fbus.inst_pc] : PCSEL_SEQ;
            fbus.ctl_br_taken  = p_tk.exists(fbus.inst_pc) ? p_tk[fbus.inst_pc] : 1'b0;
            fbus.ctl_jr_target = p_jr.exists(fbus.inst_pc) ? p_jr[fbus.inst_pc] : 32'd0;
            fbus.ctl_sys       = p_sys.exists(fbus.inst_pc) ? p_sys[fbus.inst_pc] : 1'b0;
        end
    end

    task automatic check_reset_vals(input string name);
        check32({name, "_imem_req"}, {31'd0, fbus.imem_req}, 32'd0);
        check32({name, "_inst_valid"}, {31'd0, fbus.inst_valid}, 32'd0);
        check32({name, "_inst"}, fbus.inst, 32'd0);
        check32({name, "_inst_pc"}, fbus.inst_pc, 32'd0);
        check32({name, "_halted"}, {31'd0, halted}, 32'd0);
        check32({name, "_addr_err"}, {31'd0, addr_err}, 32'd0);
`ifdef MIPS_FETCH_PERF_EN
        check32({name, "_perf_fetched"}, perf_fetched, 32'd0);
        check32({name, "_perf_stall"}, perf_stall, 32'd0);
`endif
    endtask

    task automatic do_reset(input int gd, input int rd, input int st);
        rst = 1'b1;
        gnt_dly = gd; rv_dly = rd; def_stall = st;
        rv_pend = 1'b0; stale = 1'b0; gnt_cnt = 0; stall_cnt = 0;
        req_seen = 1'b0; chk_halt = 1'b0; ready_en = 1'b1;
        q.delete(); exp_g.delete(); grant_log.delete();
        p_inst.delete(); p_sel.delete(); p_tk.delete(); p_jr.delete(); p_sys.delete(); p_stall.delete();
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input bit h, input bit e);
        exp_t x;
        x.pc = pc; x.halt_after = h; x.err_after = e;
        q.push_back(x);
        exp_g.push_back(pc);
    endtask

    task automatic push_seq(input logic [31:0] from, input logic [31:0] to);
        for (logic [31:0] a = from; a <= to; a += 32'd4) push(a, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (q.size() > 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        ready_en = 1'b0;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d entries left, required 0", name, q.size());
        end
    endtask

    task automatic finish_checks(input string name);
        repeat (6) @(negedge clk);
        check32({name, "_grant_count"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check32({name, "_grant_addr"}, grant_log[i], exp_g[i]);
    endtask

    task automatic halt_quiet(input string name, input bit err);
        repeat (8) begin
            @(negedge clk);
            #1;
            check32({name, "_no_req"}, {31'd0, fbus.imem_req}, 32'd0);
        end
        check32({name, "_halted"}, {31'd0, halted}, 32'd1);
        check32({name, "_addr_err"}, {31'd0, addr_err}, {31'd0, err});
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        // Sequential fetch, zero-latency memory.
        do_reset(0, 0, 0);
        push_seq(32'h0040_0000, 32'h0040_0008);
        exp_g.push_back(32'h0040_000C);
        wait_done("seq");
        finish_checks("seq");

        // Taken beq at 0x400010, imm 3: delay slot 0x400014, target 0x400014+12.
        do_reset(0, 0, 0);
        p_inst[32'h0040_0010] = 32'h1000_0003;
        p_sel[32'h0040_0010] = PCSEL_BR;
        p_tk[32'h0040_0010] = 1'b1;
        push_seq(32'h0040_0000, 32'h0040_0014);
        push(32'h0040_0020, 1'b0, 1'b0);
        push(32'h0040_0024, 1'b0, 1'b0);
        exp_g.push_back(32'h0040_0028);
        wait_done("beq_taken");
        finish_checks("beq_taken");

        // Not-taken beq falls through.
        do_reset(0, 0, 0);
        p_inst[32'h0040_0010] = 32'h1000_0003;
        p_sel[32'h0040_0010] = PCSEL_BR;
        p_tk[32'h0040_0010] = 1'b0;
        push_seq(32'h0040_0000, 32'h0040_0018);
        exp_g.push_back(32'h0040_001C);
        wait_done("beq_nt");
        finish_checks("beq_nt");

        // j at 0x400020, instr_index 0x0100040 -> 0x00400100.
        do_reset(0, 0, 0);
        p_inst[32'h0040_0020] = 32'h0810_0040;
        p_sel[32'h0040_0020] = PCSEL_J;
        push_seq(32'h0040_0000, 32'h0040_0024);
        push(32'h0040_0100, 1'b0, 1'b0);
        push(32'h0040_0104, 1'b0, 1'b0);
        exp_g.push_back(32'h0040_0108);
        wait_done("jump");
        finish_checks("jump");

        // jr to misaligned 0x00400202: delay slot delivered, then halt with addr_err.
        do_reset(0, 0, 0);
        p_sel[32'h0040_0008] = PCSEL_JR;
        p_jr[32'h0040_0008] = 32'h0040_0202;
        push_seq(32'h0040_0000, 32'h0040_0008);
        push(32'h0040_000C, 1'b1, 1'b1);
        wait_done("jr_mis");
        finish_checks("jr_mis");
        halt_quiet("jr_mis", 1'b1);

        // Slow memory (gnt after 3, rvalid 2 after gnt) and 4-cycle decode stalls.
        do_reset(3, 2, 4);
        push_seq(32'h0040_0000, 32'h0040_0008);
        exp_g.push_back(32'h0040_000C);
        wait_done("slow");
        finish_checks("slow");

        // Syscall at 0x400030: halt, delay slot never requested.
        do_reset(0, 0, 0);
        p_sys[32'h0040_0030] = 1'b1;
        push_seq(32'h0040_0000, 32'h0040_002C);
        push(32'h0040_0030, 1'b1, 1'b0);
        wait_done("sys");
        finish_checks("sys");
        halt_quiet("sys", 1'b0);

        // Reset pulse while waiting for rvalid; the late rvalid carries poison data.
        do_reset(0, 2, 0);
        begin
            int t = 0;
            while (grant_log.size() == 0 && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            check32("midrst_first_grant", grant_log.size(), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        stale = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        push(32'h0040_0000, 1'b0, 1'b0);
        push(32'h0040_0004, 1'b0, 1'b0);
        exp_g.push_back(32'h0040_0008);
        wait_done("midrst");
        finish_checks("midrst");

`ifdef MIPS_FETCH_PERF_EN
        // 5 accepts with 2+3+2 stall cycles.
        do_reset(0, 0, 0);
        p_stall[32'h0040_0000] = 2;
        p_stall[32'h0040_0008] = 3;
        p_stall[32'h0040_0010] = 2;
        push_seq(32'h0040_0000, 32'h0040_0010);
        wait_done("perf");
        check32("perf_fetched", perf_fetched, 32'd5);
        check32("perf_stall", perf_stall, 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
